dmem_wbuf: RTL and testbench

DMEM_WBUF -- requirements
Module: dmem_wbuf

---
 rtl/dmem_wbuf.sv | 196 +++++++++++++++++++
 tb/tb_dmem_wbuf.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wbuf.sv
// Data-memory port with a posted-write FIFO in front of a req/ack single-port RAM.
// Define DMEM_WBUF_FWD_EN to let loads complete from matching buffered stores.
module dmem_wbuf #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        ram_req,
    output logic        ram_we,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack
);

`ifdef DMEM_WBUF_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_valid_q, rd_valid_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          ram_req_q, ram_req_d;
    logic          ram_we_q, ram_we_d;
    logic [29:0]   ram_addr_q, ram_addr_d;
    logic [31:0]   ram_wdata_q, ram_wdata_d;

    logic [29:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic          is_load, full, push, pop;
    logic          fwd_hit, load_done, need_read;
    logic [31:0]   fwd_data;
    logic          unused_bits;

    assign unused_bits = ^ALUResult[1:0];

    // A simultaneous store and load is treated as a store only.
    assign is_load = MemRead & ~MemWrite;
    assign full    = (count_q == CW'(DEPTH));
    assign push    = MemWrite & ~full;
    assign pop     = (state_q == WRITE) & ram_ack;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_q] <= ALUResult[31:2];
            data_mem[tail_q] <= WriteData;
        end
    end

    generate
        if (FWD_EN) begin : g_fwd
            logic [DEPTH-1:0] match;
            logic [31:0]      ent_data [DEPTH];
            // Entry gi is the gi-th oldest; higher gi means younger.
            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
                logic [PW-1:0] idx;
                assign idx           = head_q + PW'(gi);
                assign match[gi]     = (CW'(gi) < count_q) && (addr_mem[idx] == ALUResult[31:2]);
                assign ent_data[gi]  = data_mem[idx];
            end
            always_comb begin
                fwd_hit  = 1'b0;
                fwd_data = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (match[i]) begin
                        fwd_hit  = 1'b1;
                        fwd_data = ent_data[i];
                    end
                end
            end
        end else begin : g_nofwd
            assign fwd_hit  = 1'b0;
            assign fwd_data = '0;
        end
    endgenerate

    assign load_done = is_load & (rd_valid_q | fwd_hit);
    // Without forwarding a load may only go to RAM once every older store has landed.
    assign need_read = is_load & ~rd_valid_q & ~fwd_hit & (FWD_EN || (count_q == '0));

    always_comb begin
        Stall    = 1'b0;
        ReadData = '0;
        if (reset) begin
            Stall = (MemWrite & full) | (is_load & ~load_done);
            if (is_load & rd_valid_q) begin
                ReadData = rd_data_q;
            end else if (is_load & fwd_hit) begin
                ReadData = fwd_data;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
        if (is_load & rd_valid_q) begin
            rd_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (need_read) begin
                    state_d = READ;
                end else if (count_q != '0) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (ram_ack) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (ram_ack) begin
                    rd_data_d  = ram_rdata;
                    rd_valid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM port outputs are registered from the next state so they are glitch-free.
    always_comb begin
        ram_req_d   = (state_d != IDLE);
        ram_we_d    = (state_d == WRITE);
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (state_d == WRITE) begin
            ram_addr_d  = addr_mem[head_d];
            ram_wdata_d = data_mem[head_d];
        end else if (state_d == READ) begin
            ram_addr_d  = ALUResult[31:2];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf with a behavioural req/ack RAM whose ack latency is set per test.
// Forwarding scenarios are selected by DMEM_WBUF_FWD_EN, matching the design build.
module tb_dmem_wbuf;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite, MemRead;
    logic [31:0] ALUResult, WriteData, ReadData;
    logic        Stall;
    logic        ram_req, ram_we;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic        ram_ack = 1'b0;

    int checks = 0;
    int passed = 0;

    int ack_lat = 0;
    int req_cnt = 0;
    int n_wr = 0, n_rd = 0, n_rd_req = 0, wr_at_rd_req = -1;
    logic [31:0] ram_mem [logic [29:0]];
    logic [29:0] wr_addr_log [$];
    logic [31:0] wr_data_log [$];

    dmem_wbuf #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
        .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack)
    );

    always #5 clk = ~clk;

    // RAM model: acks on the ack_lat-th consecutive req cycle (never when ack_lat==0).
    always @(posedge clk) begin
        if (reset && ram_req && ram_ack) begin
            if (ram_we) begin
                ram_mem[ram_addr] = ram_wdata;
                wr_addr_log.push_back(ram_addr);
                wr_data_log.push_back(ram_wdata);
                n_wr++;
                $display("RAM write addr=%h data=%h", ram_addr, ram_wdata);
            end else begin
                n_rd++;
                $display("RAM read  addr=%h data=%h", ram_addr, ram_rdata);
            end
        end
        #2;
        if (ram_req) begin
            req_cnt++;
            if (req_cnt == 1 && !ram_we) begin
                n_rd_req++;
                wr_at_rd_req = n_wr;
            end
            ram_ack   = (ack_lat > 0) && (req_cnt >= ack_lat);
            ram_rdata = ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : 32'h0;
        end else begin
            req_cnt   = 0;
            ram_ack   = 1'b0;
            ram_rdata = 32'h0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        ALUResult = 32'h0;
        WriteData = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        MemWrite = 1'b0;
        MemRead = 1'b1;
        ALUResult = 32'h200;
        WriteData = 32'h0;
        #12;
        checks++; if (Stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", Stall); else passed++;
        checks++; if (ReadData !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", ReadData); else passed++;
        checks++; if ({ram_req, ram_we, ram_addr, ram_wdata} !== 64'h0) $display("FAIL reset_ram: got req=%b we=%b addr=%h wdata=%h expected all 0", ram_req, ram_we, ram_addr, ram_wdata); else passed++;
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        $display("reset released");
    endtask

    task automatic test_full();
        int t;
        ack_lat = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            MemWrite  = 1'b1;
            ALUResult = 32'h40 + 32'(4 * k);
            WriteData = 32'hA0 + 32'(k);
            @(negedge clk);
            $display("store %0d addr=%h stall=%b", k + 1, ALUResult, Stall);
            checks++; if (Stall !== (k == 4)) $display("FAIL full_stall%0d: got %b expected %b", k + 1, Stall, (k == 4)); else passed++;
            if (k >= 2) begin
                checks++; if ({ram_req, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 30'h10, 32'hA0}) $display("FAIL full_head%0d: got req=%b we=%b addr=%h wdata=%h expected 1 1 10 a0", k, ram_req, ram_we, ram_addr, ram_wdata); else passed++;
            end
        end
        step();
        ack_lat = 1;
        @(negedge clk);
        checks++; if (Stall !== 1'b1) $display("FAIL full_ack_same_cycle: got %b expected 1", Stall); else passed++;
        step();
        @(negedge clk);
        checks++; if (Stall !== 1'b0) $display("FAIL full_retry: got %b expected 0", Stall); else passed++;
        step();
        idle_inputs();
        t = 0;
        while (t < 100 && !(n_wr == 5 && !ram_req)) begin
            @(negedge clk);
            t++;
        end
        checks++; if (n_wr !== 5) $display("FAIL full_drain_count: got %0d expected 5", n_wr); else passed++;
        for (int k = 0; k < 5 && k < n_wr; k++) begin
            checks++; if ({wr_addr_log[k], wr_data_log[k]} !== {30'h10 + 30'(k), 32'hA0 + 32'(k)}) $display("FAIL full_order%0d: got addr=%h data=%h expected addr=%h data=%h", k, wr_addr_log[k], wr_data_log[k], 30'h10 + 30'(k), 32'hA0 + 32'(k)); else passed++;
        end
    endtask

    task automatic test_read_miss();
        int base_rd;
        base_rd = n_rd;
        ack_lat = 3;
        ram_mem[30'h80] = 32'hCAFE0001;
        for (int c = 0; c < 4; c++) begin
            step();
            MemRead   = 1'b1;
            ALUResult = 32'h200;
            @(negedge clk);
            $display("load 0x200 cycle %0d stall=%b req=%b", c, Stall, ram_req);
            checks++; if ({Stall, ReadData} !== {1'b1, 32'h0}) $display("FAIL miss_stall%0d: got stall=%b rdata=%h expected 1 0", c, Stall, ReadData); else passed++;
            if (c >= 1) begin
                checks++; if ({ram_req, ram_we, ram_addr} !== {1'b1, 1'b0, 30'h80}) $display("FAIL miss_req%0d: got req=%b we=%b addr=%h expected 1 0 80", c, ram_req, ram_we, ram_addr); else passed++;
            end
        end
        step();
        @(negedge clk);
        checks++; if ({Stall, ReadData} !== {1'b0, 32'hCAFE0001}) $display("FAIL miss_done: got stall=%b rdata=%h expected 0 cafe0001", Stall, ReadData); else passed++;
        step();
        idle_inputs();
        @(negedge clk);
        checks++; if ({ram_req, ReadData} !== 33'h0) $display("FAIL miss_after: got req=%b rdata=%h expected 0 0", ram_req, ReadData); else passed++;
        checks++; if (n_rd !== base_rd + 1) $display("FAIL miss_read_count: got %0d expected %0d", n_rd, base_rd + 1); else passed++;
    endtask

`ifdef DMEM_WBUF_FWD_EN
    task automatic test_forward();
        int base_rdreq, base_wr, t;
        base_rdreq = n_rd_req;
        base_wr = n_wr;
        ack_lat = 0;
        step();
        MemWrite = 1'b1; ALUResult = 32'h100; WriteData = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (Stall !== 1'b0) $display("FAIL fwd_store: got %b expected 0", Stall); else passed++;
        step();
        MemWrite = 1'b0; MemRead = 1'b1;
        @(negedge clk);
        $display("fwd load 0x100 rdata=%h stall=%b", ReadData, Stall);
        checks++; if ({Stall, ReadData} !== {1'b0, 32'hDEADBEEF}) $display("FAIL fwd_hit: got stall=%b rdata=%h expected 0 deadbeef", Stall, ReadData); else passed++;
        step();
        idle_inputs();
        @(negedge clk);
        checks++; if (ReadData !== 32'h0) $display("FAIL fwd_after: got %h expected 0", ReadData); else passed++;
        step();
        MemWrite = 1'b1; ALUResult = 32'h104; WriteData = 32'h11;
        step();
        WriteData = 32'h22;
        step();
        MemWrite = 1'b0; MemRead = 1'b1;
        @(negedge clk);
        $display("fwd load 0x104 rdata=%h stall=%b", ReadData, Stall);
        checks++; if ({Stall, ReadData} !== {1'b0, 32'h22}) $display("FAIL fwd_youngest: got stall=%b rdata=%h expected 0 22", Stall, ReadData); else passed++;
        step();
        idle_inputs();
        @(negedge clk);
        checks++; if (n_rd_req !== base_rdreq) $display("FAIL fwd_no_read: got %0d read reqs expected %0d", n_rd_req, base_rdreq); else passed++;
        ack_lat = 1;
        t = 0;
        while (t < 100 && !(n_wr == base_wr + 3 && !ram_req)) begin
            @(negedge clk);
            t++;
        end
        checks++; if (n_wr !== base_wr + 3) $display("FAIL fwd_drain: got %0d writes expected %0d", n_wr, base_wr + 3); else passed++;
        step();
        MemRead = 1'b1; ALUResult = 32'h104;
        t = 0;
        @(negedge clk);
        while (t < 50 && Stall) begin
            step();
            @(negedge clk);
            t++;
        end
        checks++; if ({Stall, ReadData} !== {1'b0, 32'h22}) $display("FAIL fwd_miss_read: got stall=%b rdata=%h expected 0 22", Stall, ReadData); else passed++;
        checks++; if (n_rd_req !== base_rdreq + 1) $display("FAIL fwd_miss_req: got %0d read reqs expected %0d", n_rd_req, base_rdreq + 1); else passed++;
        step();
        idle_inputs();
    endtask
`else
    task automatic test_drain_before_read();
        int base_wr, base_rdreq, t;
        base_wr = n_wr;
        base_rdreq = n_rd_req;
        ack_lat = 2;
        step();
        MemWrite = 1'b1; ALUResult = 32'h300; WriteData = 32'h33;
        step();
        ALUResult = 32'h304; WriteData = 32'h44;
        step();
        MemWrite = 1'b0; MemRead = 1'b1; ALUResult = 32'h300;
        @(negedge clk);
        checks++; if (Stall !== 1'b1) $display("FAIL drain_first_stall: got %b expected 1", Stall); else passed++;
        t = 0;
        while (t < 60 && Stall) begin
            step();
            @(negedge clk);
            t++;
        end
        $display("load 0x300 done after %0d cycles rdata=%h", t, ReadData);
        checks++; if ({Stall, ReadData} !== {1'b0, 32'h33}) $display("FAIL drain_load: got stall=%b rdata=%h expected 0 33", Stall, ReadData); else passed++;
        checks++; if (wr_at_rd_req !== base_wr + 2) $display("FAIL drain_order: got %0d writes before read req expected %0d", wr_at_rd_req, base_wr + 2); else passed++;
        checks++; if (n_rd_req !== base_rdreq + 1) $display("FAIL drain_read_req: got %0d expected %0d", n_rd_req, base_rdreq + 1); else passed++;
        if (n_wr >= base_wr + 2) begin
            checks++; if ({wr_data_log[base_wr], wr_data_log[base_wr + 1]} !== {32'h33, 32'h44}) $display("FAIL drain_data: got %h %h expected 33 44", wr_data_log[base_wr], wr_data_log[base_wr + 1]); else passed++;
        end
        step();
        idle_inputs();
    endtask
`endif

    task automatic test_reset_mid_write();
        int base_wr, t;
        bit seen_req;
        ack_lat = 0;
        step();
        MemWrite = 1'b1; ALUResult = 32'h600; WriteData = 32'h66;
        step();
        idle_inputs();
        t = 0;
        @(negedge clk);
        while (t < 20 && !ram_req) begin
            @(negedge clk);
            t++;
        end
        checks++; if (ram_req !== 1'b1) $display("FAIL rst_wr_enter: got req=%b expected 1", ram_req); else passed++;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        $display("reset asserted mid-write req=%b", ram_req);
        checks++; if ({ram_req, ram_we, ram_addr, ram_wdata, Stall} !== 65'h0) $display("FAIL rst_wr_drop: got req=%b we=%b addr=%h wdata=%h stall=%b expected all 0", ram_req, ram_we, ram_addr, ram_wdata, Stall); else passed++;
        base_wr = n_wr;
        ack_lat = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen_req = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ram_req) seen_req = 1'b1;
        end
        checks++; if ({seen_req, 32'(n_wr)} !== {1'b0, 32'(base_wr)}) $display("FAIL rst_wr_none: got req_seen=%b writes=%0d expected 0 %0d", seen_req, n_wr, base_wr); else passed++;
        ack_lat = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            MemWrite = 1'b1; ALUResult = 32'h700 + 32'(4 * k); WriteData = 32'(k);
            @(negedge clk);
            checks++; if (Stall !== (k == 4)) $display("FAIL rst_count%0d: got %b expected %b", k + 1, Stall, (k == 4)); else passed++;
        end
        step();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_full();
        test_read_miss();
`ifdef DMEM_WBUF_FWD_EN
        test_forward();
`else
        test_drain_before_read();
`endif
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
        $fatal(1, "timeout");
    end
endmodule
